// File: rtl/decoder_pkg.sv
// Shared sizing for the select decoder: default select width and the derived output width.
// Latency: n/a (constants only); backpressure: n/a.
package decoder_pkg;

  localparam int DEF_SEL_W = 3;

  // The output width always tracks the select width; use this rather than a free parameter.
  function automatic int out_width(input int sel_w);
    return 1 << sel_w;
  endfunction

  localparam int DEF_OUT_W = out_width(DEF_SEL_W);

endpackage

// File: rtl/decoder_if.sv
// Bundles the decoder's select/enable inputs and registered decode outputs.
// Latency: n/a (wires only); backpressure: none, outputs are presented every cycle.
interface decoder_if
  import decoder_pkg::*;
#(
  parameter int SEL_W = DEF_SEL_W,
  parameter int OUT_W = out_width(SEL_W)
);

  logic             enb_;
  logic [SEL_W-1:0] sel;
  logic [OUT_W-1:0] o;
  logic             o_valid;

  modport master (output enb_, output sel, input o, input o_valid);
  modport slave  (input enb_, input sel, output o, output o_valid);

endinterface

// File: rtl/decoder_core.sv
// Combinational binary-to-one-hot conversion, gated by an active-high enable.
// Latency: zero (pure logic); backpressure: none.
module decoder_core
  import decoder_pkg::*;
#(
  parameter int SEL_W = DEF_SEL_W,
  parameter int OUT_W = out_width(SEL_W)
) (
  input  logic [SEL_W-1:0] sel,
  input  logic             en,
  output logic [OUT_W-1:0] onehot
);

  always_comb begin
    onehot = '0;
    if (en) begin
      onehot[sel] = 1'b1;
    end
  end

endmodule

// File: rtl/decoder.sv
// Registered select decoder: o is one-hot of sel when enb_ is low, zero otherwise.
// Latency: one clk cycle, no input-to-output combinational path; backpressure: none.
module decoder
  import decoder_pkg::*;
#(
  parameter int SEL_W = DEF_SEL_W,
  parameter int OUT_W = out_width(SEL_W)
) (
  input  logic             clk,
  input  logic             rst,
  output logic [OUT_W-1:0] o,
  input  logic             enb_,
  input  logic [SEL_W-1:0] sel,
  output logic             o_valid
);

  logic [OUT_W-1:0] onehot;

  decoder_core #(
    .SEL_W (SEL_W),
    .OUT_W (OUT_W)
  ) u_core (
    .sel    (sel),
    .en     (~enb_),
    .onehot (onehot)
  );

  // Asynchronous clear so a reset mid-cycle drops the output without waiting for clk.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      o       <= '0;
      o_valid <= 1'b0;
    end else begin
      o       <= onehot;
      o_valid <= ~enb_;
    end
  end

endmodule

// File: tb/tb_decoder.sv
// Scoreboard bench for decoder: driver queues expected results, monitor compares one cycle later.
module tb_decoder;

  localparam int SEL_W = 3;
  localparam int OUT_W = 8;

  typedef struct packed {
    logic [OUT_W-1:0] o;
    logic             v;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic chk_on = 1'b0;
  int   vectors = 0;
  int   miscompares = 0;
  exp_t exp_q[$];

  decoder_if #(.SEL_W(SEL_W)) bus ();

  decoder dut (
    .clk     (clk),
    .rst     (rst),
    .o       (bus.o),
    .enb_    (bus.enb_),
    .sel     (bus.sel),
    .o_valid (bus.o_valid)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [OUT_W-1:0] got_o, input logic got_v,
                       input logic [OUT_W-1:0] req_o, input logic req_v);
    vectors++;
    if (got_o !== req_o || got_v !== req_v) begin
      miscompares++;
      $display("FAIL %s: got o=%b o_valid=%b, required o=%b o_valid=%b",
               name, got_o, got_v, req_o, req_v);
    end
  endtask

  // Drive one cycle of inputs at the falling edge and queue the expected registered result.
  task automatic cyc(input logic r, input logic enb, input logic [SEL_W-1:0] s,
                     input logic [OUT_W-1:0] eo, input logic ev);
    exp_t e;
    @(negedge clk);
    rst      = r;
    bus.enb_ = enb;
    bus.sel  = s;
    e.o = eo;
    e.v = ev;
    exp_q.push_back(e);
  endtask

  // Monitor: every cycle the DUT presents a result, compare against the oldest expectation.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check("scoreboard", bus.o, bus.o_valid, e.o, e.v);
      end
    end
  end

  // Structural checker: at most one bit set, exactly one iff o_valid.
  always @(negedge clk) begin
    if (chk_on) begin
      vectors++;
      if ($countones(bus.o) > 1 || (($countones(bus.o) == 1) != (bus.o_valid == 1'b1))) begin
        miscompares++;
        $display("FAIL onehot: got o=%b o_valid=%b, required at most one bit set, one iff valid",
                 bus.o, bus.o_valid);
      end
    end
  end

  initial begin
    logic [OUT_W-1:0] walk [8];
    int waited;
    walk[0] = 8'b00000001; walk[1] = 8'b00000010; walk[2] = 8'b00000100; walk[3] = 8'b00001000;
    walk[4] = 8'b00010000; walk[5] = 8'b00100000; walk[6] = 8'b01000000; walk[7] = 8'b10000000;

    bus.enb_ = 1'b0;
    bus.sel  = 3'd3;
    #1;
    check("reset_immediate", bus.o, bus.o_valid, 8'b00000000, 1'b0);
    chk_on = 1'b1;

    // Reset held across two edges with decode-enabling inputs.
    cyc(1'b1, 1'b0, 3'd5, 8'b00000000, 1'b0);
    cyc(1'b1, 1'b0, 3'd7, 8'b00000000, 1'b0);

    // First edge after release: disabled decode.
    cyc(1'b0, 1'b1, 3'd0, 8'b00000000, 1'b0);

    for (int i = 0; i < 8; i++) begin
      cyc(1'b0, 1'b0, 3'(i), walk[i], 1'b1);
    end

    cyc(1'b0, 1'b0, 3'd5, 8'b00100000, 1'b1);
    cyc(1'b0, 1'b1, 3'd5, 8'b00000000, 1'b0);
    cyc(1'b0, 1'b1, 3'd2, 8'b00000000, 1'b0);

    // Enable and select change together.
    cyc(1'b0, 1'b1, 3'd3, 8'b00000000, 1'b0);
    cyc(1'b0, 1'b0, 3'd6, 8'b01000000, 1'b1);

    // Mid-cycle asynchronous reset after a decode of 7.
    cyc(1'b0, 1'b0, 3'd7, 8'b10000000, 1'b1);
    @(posedge clk);
    #3;
    rst = 1'b1;
    #1;
    check("async_reset", bus.o, bus.o_valid, 8'b00000000, 1'b0);
    cyc(1'b1, 1'b0, 3'd7, 8'b00000000, 1'b0);
    cyc(1'b0, 1'b0, 3'd7, 8'b10000000, 1'b1);
    cyc(1'b0, 1'b0, 3'd0, 8'b00000001, 1'b1);

    waited = 0;
    while (exp_q.size() > 0 && waited < 20) begin
      @(posedge clk);
      waited++;
    end
    #2;
    if (exp_q.size() > 0) begin
      miscompares++;
      $display("FAIL drain: got %0d pending expectations, required 0", exp_q.size());
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
